// File: rtl/mux_share_arbiter.sv
// -----------------------------------------------------------------------------
// mux_share_arbiter
//
// Round-robin arbiter that lends one shared mux-tree datapath (writeback/bus
// mux built from a chain of 2:1 muxes) to one of NREQ requesters at a time.
//
// Operation:
//   IDLE   : search for a request starting at the priority pointer and
//            wrapping modulo NREQ. Load the winner's index onto the select
//            lines and move to SETTLE.
//   SETTLE : hold for exactly one cycle. The select lines are stable but no
//            grant is issued, so the mux tree has a full cycle to settle.
//   OWN    : assert the one-hot grant. Stay here until the owner signals
//            done, withdraws its request, or the optional watchdog expires.
//            On exit the pointer moves to the index after the owner.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a hold counter limits ownership to MAXHOLD cycles. Expiry
//   without inDone forces release and pulses outTimeout for one cycle.
//   When undefined, there is no counter, ownership is unlimited, and
//   outTimeout is tied low.
//
// Parameters:
//   NREQ    - number of requesters (power of two, 2..8)
//   SELW    - select width, log2(NREQ)
//   MAXHOLD - watchdog limit in OWN cycles (ARB_TIMEOUT_EN only)
//
// Ports:
//   inClk      in   clock, rising edge
//   inRst      in   asynchronous active-high reset
//   inReq      in   per-requester level request
//   inDone     in   current owner finished (sampled in OWN only)
//   outSel     out  binary select to the mux tree (current/pending owner)
//   outGnt     out  one-hot grant, zero when there is no owner
//   outBusy    out  high in SETTLE and OWN
//   outTimeout out  one-cycle pulse when the watchdog forces release
// -----------------------------------------------------------------------------
module mux_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int SELW    = 2,
  parameter int MAXHOLD = 15
) (
  input  logic            inClk,
  input  logic            inRst,
  input  logic [NREQ-1:0] inReq,
  input  logic            inDone,
  output logic [SELW-1:0] outSel,
  output logic [NREQ-1:0] outGnt,
  output logic            outBusy,
  output logic            outTimeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OWN    = 2'd2
  } state_e;

  state_e          state_q;
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] sel_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;

  // ---------------------------------------------------------------------------
  // Round-robin search. Offsets are scanned from the highest down to zero so
  // that the last hit (the smallest offset from ptr_q) is the one kept.
  // Adding offsets in SELW bits wraps modulo NREQ because NREQ is a power of 2.
  // ---------------------------------------------------------------------------
  logic            any_req;
  logic [SELW-1:0] pick_d;
  logic [SELW-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    any_req = 1'b0;
    pick_d  = ptr_q;
    cand    = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr_q + SELW'(i);
      if (inReq[cand]) begin
        any_req = 1'b1;
        pick_d  = cand;
      end
    end
  end

  // Normal release: owner finished or dropped its request.
  logic owner_release;
  assign owner_release = inDone | ~inReq[sel_q];

  // Watchdog expiry, meaningful only while in OWN.
  logic wd_fire;

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = (MAXHOLD < 2) ? 1 : $clog2(MAXHOLD + 1);

  logic [CNTW-1:0] hold_q;
  logic [CNTW-1:0] hold_d;
  logic            timeout_q;

  // Saturating count of OWN cycles. hold_q is 0 in the first OWN cycle, so
  // hold_d reaching MAXHOLD marks the last permitted OWN cycle.
  always_comb begin
    hold_d = hold_q;
    if (hold_q != CNTW'(MAXHOLD)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  assign wd_fire = (hold_d == CNTW'(MAXHOLD));

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Done in the same cycle as expiry counts as a normal release.
      timeout_q <= (state_q == ST_OWN) && wd_fire && !inDone;
      if (state_q == ST_OWN) begin
        hold_q <= hold_d;
      end else begin
        hold_q <= '0;
      end
    end
  end

  assign outTimeout = timeout_q;
`else
  assign wd_fire    = 1'b0;
  assign outTimeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          // With no request, sel_q keeps its last value.
          if (any_req) begin
            sel_q   <= pick_d;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          // Entered unconditionally, even if the pending requester dropped;
          // the first OWN cycle then releases it.
          gnt_q   <= NREQ'(1) << sel_q;
          state_q <= ST_OWN;
        end

        ST_OWN: begin
          if (owner_release || wd_fire) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign outSel  = sel_q;
  assign outGnt  = gnt_q;
  assign outBusy = busy_q;

endmodule
